// File: rtl/lcd_write_if.sv
// Byte handshake from the upstream sequencer plus the HD44780-style LCD bus.
interface lcd_write_if;
  logic       in_valid;
  logic       in_rs;
  logic [7:0] in_data;
  logic       in_ready;
  logic       rs;
  logic       rw;
  logic       en;
  logic [7:0] dout;
  logic       busy;

  // Controller side: consumes bytes, drives the LCD pins.
  modport slave (
    input  in_valid,
    input  in_rs,
    input  in_data,
    output in_ready,
    output rs,
    output rw,
    output en,
    output dout,
    output busy
  );

  // Sequencer / environment side.
  modport master (
    output in_valid,
    output in_rs,
    output in_data,
    input  in_ready,
    input  rs,
    input  rw,
    input  en,
    input  dout,
    input  busy
  );
endinterface

// File: rtl/lcd_write_ctrl.sv
// LCD write controller: takes one byte at a time from a sequencer and plays
// it onto the LCD bus as setup -> enable pulse -> hold -> execution wait.
// Clear/home commands (0x01..0x03 with rs = 0) get the long execution wait.
module lcd_write_ctrl #(
  parameter int unsigned SETUP_CYC    = 4,
  parameter int unsigned EN_HIGH_CYC  = 25,
  parameter int unsigned HOLD_CYC     = 2,
  parameter int unsigned CMD_WAIT_CYC = 4000,
  parameter int unsigned CLR_WAIT_CYC = 164000
) (
  input  logic        clk,
  input  logic        rst_n,
  lcd_write_if.slave  bus
);

  // Counter must reach the largest phase length minus one without wrapping.
  localparam int unsigned MAX_WAIT = (CLR_WAIT_CYC > CMD_WAIT_CYC) ? CLR_WAIT_CYC : CMD_WAIT_CYC;
  localparam int unsigned MAX_EW   = (EN_HIGH_CYC > MAX_WAIT) ? EN_HIGH_CYC : MAX_WAIT;
  localparam int unsigned MAX_SH   = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int unsigned MAX_CNT  = (MAX_SH > MAX_EW) ? MAX_SH : MAX_EW;
  localparam int unsigned CNT_W    = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic [7:0]       dout_q, dout_d;
  logic             en_q, en_d;
  logic             clr_cmd;
  logic [CNT_W-1:0] wait_last;

  // Clear display / return home need the long execution time.
  assign clr_cmd   = !rs_q && ((dout_q == 8'h01) || (dout_q == 8'h02) || (dout_q == 8'h03));
  assign wait_last = clr_cmd ? CLR_LAST : CMD_LAST;

  // Next-state, counter and bus-latch logic; en_d is computed from the phase
  // being entered so that en is a clean flop output tied to PULSE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    rs_d    = rs_q;
    dout_d  = dout_q;
    en_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.in_valid) begin
          state_d = SETUP;
          rs_d    = bus.in_rs;
          dout_d  = bus.in_data;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = PULSE;
          cnt_d   = '0;
          en_d    = 1'b1;
        end
      end
      PULSE: begin
        en_d = 1'b1;
        if (cnt_q == EN_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
          en_d    = 1'b0;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (cnt_q == wait_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and LCD pin registers; reset drops en immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      dout_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      dout_q  <= dout_d;
      en_q    <= en_d;
    end
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.rw       = 1'b0;
  assign bus.en       = en_q;
  assign bus.rs       = rs_q;
  assign bus.dout     = dout_q;

  // en must only ever be seen high while in the enable phase.
  en_only_in_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    en_q |-> (state_q == PULSE));

endmodule

// File: doc/lcd_write_ctrl.md
LCD_WRITE_CTRL -- requirements
Module: lcd_write_ctrl

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 4, clk cycles rs/dout stable before en rises (>=1).
REQ-002 SHALL have parameter EN_HIGH_CYC, default 25, clk cycles en held high (>=1).
REQ-003 SHALL have parameter HOLD_CYC, default 2, clk cycles rs/dout held after en falls (>=1).
REQ-004 SHALL have parameter CMD_WAIT_CYC, default 4000, execution wait for ordinary bytes (>=1).
REQ-005 SHALL have parameter CLR_WAIT_CYC, default 164000, execution wait for clear/home commands (>=1).
REQ-006 SHALL have port clk  input  1  single clock, all state on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port in_valid  input  1  upstream sequencer offers a byte.
REQ-009 SHALL have port in_rs  input  1  0 = command byte, 1 = character data byte.
REQ-010 SHALL have port in_data  input  8  byte to write.
REQ-011 SHALL have port in_ready  output  1  block can accept a byte this cycle.
REQ-012 SHALL have port rs  output  1  LCD register select.
REQ-013 SHALL have port rw  output  1  LCD read/write, write-only block.
REQ-014 SHALL have port en  output  1  LCD enable strobe.
REQ-015 SHALL have port dout  output  8  LCD data bus.
REQ-016 SHALL have port busy  output  1  transaction in progress, inverse of in_ready.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, PULSE, HOLD, WAIT, with in_ready = 1 only in IDLE.
REQ-018 SHALL accept a byte on a rising edge where in_valid && in_ready: latch in_rs -> rs, in_data -> dout, clear counter, go SETUP.
REQ-019 SHALL ignore in_valid in all states other than IDLE; upstream holds in_valid/in_rs/in_data until accepted.
REQ-020 SHALL stay in SETUP SETUP_CYC cycles, en = 0, then go PULSE.
REQ-021 SHALL drive en = 1 (registered) for exactly EN_HIGH_CYC cycles in PULSE, then go HOLD.
REQ-022 SHALL keep en = 0 and rs/dout unchanged for HOLD_CYC cycles in HOLD, then go WAIT.
REQ-023 SHALL wait CLR_WAIT_CYC cycles in WAIT if latched rs = 0 and latched byte is 8'h01, 8'h02 or 8'h03; otherwise CMD_WAIT_CYC cycles; then go IDLE.
REQ-024 SHALL give, for an accept at edge k: en rises at edge k+SETUP_CYC, falls at edge k+SETUP_CYC+EN_HIGH_CYC, in_ready rises at edge k+SETUP_CYC+EN_HIGH_CYC+HOLD_CYC+W (W = selected wait).
REQ-025 SHALL give back-to-back minimum accept spacing of SETUP_CYC+EN_HIGH_CYC+HOLD_CYC+W+1 cycles.
REQ-026 SHALL keep rs and dout constant from accept until the next accept, holding the last value in IDLE.
REQ-027 SHALL tie rw to 0 at all times.
REQ-028 SHALL size counters to hold max(CLR_WAIT_CYC, CMD_WAIT_CYC, EN_HIGH_CYC) without wrap; no counter wraps during a transaction.
REQ-029 SHALL never assert en outside PULSE, including during or after reset.

Reset
REQ-030 SHALL on rst_n low, immediately and regardless of clk: state IDLE, counter 0, rs = 0, rw = 0, en = 0, dout = 8'h00, busy = 0.
REQ-031 SHALL on reset mid-operation abort the transaction with en dropping asynchronously, with no resumption after release.
REQ-032 SHALL not accept a byte on the first rising edge at which rst_n is low; the first accept is possible on the first edge with rst_n high.

Verification (bench params SETUP_CYC=2, EN_HIGH_CYC=3, HOLD_CYC=1, CMD_WAIT_CYC=5, CLR_WAIT_CYC=20)
REQ-033 SHALL cover single data byte: in_rs=1, in_data=8'h76 accepted at edge k -> rs=1, dout=8'h76 from k; en high edges k+2..k+5; in_ready back at edge k+11.
REQ-034 SHALL cover clear command: in_rs=0, in_data=8'h01 -> en timing as above; in_ready back at edge k+26; 8'h28 command waits 5, not 20.
REQ-035 SHALL cover back-to-back: in_valid held with 7 bytes "verilog" -> accepts every 12 cycles; dout order 76,65,72,69,6C,6F,67; exactly 7 en pulses.
REQ-036 SHALL cover stall/ignore: in_data changed while busy -> dout unchanged until the next accept; no extra en pulse.
REQ-037 SHALL cover reset mid-PULSE: rst_n low during en=1 -> en, rs, dout drop to 0 before the next clk edge; in_ready=1; no pulse after release until a new accept.
REQ-038 SHALL cover rw stuck at 0 and en never high while state != PULSE, checked by assertion across all scenarios.
